// File: rtl/alu_host_driver_if.sv
// Request/response handshake bundle between a host and alu_host_driver.
// The driver takes the slave modport; the requester/consumer takes master.
interface alu_host_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_host_driver.sv
// Host-side driver for the 8-bit ALU tile: sends {SYNC_NIB,op}, A, B as a 3-beat frame and returns
// the result captured RESULT_LAT cycles after the B beat. Define ALU_DRV_STATS_EN for txn_count/stall_seen.
module alu_host_driver #(
    parameter int unsigned RESULT_LAT = 2,
    parameter logic [7:0]  IDLE_BYTE  = 8'h00,
    parameter logic [3:0]  SYNC_NIB   = 4'hA
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_host_driver_if.slave host,
    output logic [7:0]       alu_ui,
    input  logic [7:0]       alu_uo,
    output logic             busy
`ifdef ALU_DRV_STATS_EN
    ,
    output logic [15:0]      txn_count,
    output logic             stall_seen
`endif
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SEND_OP = 3'd1;
    localparam logic [2:0] SEND_A  = 3'd2;
    localparam logic [2:0] SEND_B  = 3'd3;
    localparam logic [2:0] WAIT    = 3'd4;
    localparam logic [2:0] HOLD    = 3'd5;

    localparam logic [3:0] LAT_LOAD = 4'(RESULT_LAT);

    logic [2:0] state_q, state_d;
    logic [7:0] a_q, b_q;
    logic [7:0] ui_q, ui_d;
    logic [7:0] data_q;
    logic [3:0] cnt_q, cnt_d;
    logic       rsp_valid_q;
    logic       accept, capture, rsp_hs;

    assign accept = (state_q == IDLE) && host.req_valid;
    assign rsp_hs = (state_q == HOLD) && host.rsp_ready;

    // ui_d is the beat for the state being entered, so alu_ui stays a pure register.
    always_comb begin
        state_d = state_q;
        ui_d    = IDLE_BYTE;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND_OP;
                    ui_d    = {SYNC_NIB, host.req_op};
                end
            end
            SEND_OP: begin
                state_d = SEND_A;
                ui_d    = a_q;
            end
            SEND_A: begin
                state_d = SEND_B;
                ui_d    = b_q;
            end
            SEND_B: begin
                state_d = WAIT;
                cnt_d   = LAT_LOAD;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (rsp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ui_q        <= IDLE_BYTE;
            cnt_q       <= 4'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            data_q      <= 8'h00;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ui_q    <= ui_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q <= host.req_a;
                b_q <= host.req_b;
            end
            if (capture) begin
                data_q      <= alu_uo;
                rsp_valid_q <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign host.req_ready = (state_q == IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = data_q;
    assign alu_ui         = ui_q;
    assign busy           = (state_q != IDLE);

`ifdef ALU_DRV_STATS_EN
    logic [15:0] txn_q;
    logic        stall_q;

    // Waiting in HOLD without rsp_ready guarantees HOLD lasts more than one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q   <= 16'h0000;
            stall_q <= 1'b0;
        end else begin
            if (rsp_hs) txn_q <= txn_q + 16'h0001;
            if ((state_q == HOLD) && !host.rsp_ready) stall_q <= 1'b1;
        end
    end

    assign txn_count  = txn_q;
    assign stall_seen = stall_q;
`endif
endmodule

// File: tb/tb_alu_host_driver.sv
// Bench for alu_host_driver: three instances (RESULT_LAT 2, 1, 7), each with an adder ALU model that
// corrupts alu_uo outside the capture cycle; vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_alu_host_driver;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       req_valid [NDUT];
    logic [3:0] req_op    [NDUT];
    logic [7:0] req_a     [NDUT];
    logic [7:0] req_b     [NDUT];
    logic       rsp_ready [NDUT];
    logic       req_ready [NDUT];
    logic       rsp_valid [NDUT];
    logic [7:0] rsp_data  [NDUT];
    logic [7:0] alu_ui    [NDUT];
    logic [7:0] alu_uo    [NDUT];
    logic       busy      [NDUT];
`ifdef ALU_DRV_STATS_EN
    logic [15:0] txn_count  [NDUT];
    logic        stall_seen [NDUT];
`endif

    typedef struct {
        int         dut;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic score(int g, logic [7:0] data);
        sb_t e;
        check("rsp_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_dut", g, e.dut);
            check("rsp_data", int'(data), int'(e.data));
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

        alu_host_driver_if host ();
        assign host.req_valid = req_valid[g];
        assign host.req_op    = req_op[g];
        assign host.req_a     = req_a[g];
        assign host.req_b     = req_b[g];
        assign host.rsp_ready = rsp_ready[g];
        assign req_ready[g]   = host.req_ready;
        assign rsp_valid[g]   = host.rsp_valid;
        assign rsp_data[g]    = host.rsp_data;

        alu_host_driver #(.RESULT_LAT(L)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .host      (host),
            .alu_ui    (alu_ui[g]),
            .alu_uo    (alu_uo[g]),
            .busy      (busy[g])
`ifdef ALU_DRV_STATS_EN
            ,
            .txn_count (txn_count[g]),
            .stall_seen(stall_seen[g])
`endif
        );

        // ALU model: tracks beats on alu_ui; sum valid only in the L-th cycle after the B beat.
        int         beat, since_b;
        logic       armed;
        logic [7:0] ma, mb, noise;
        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                beat    <= 0;
                since_b <= 0;
                armed   <= 1'b0;
                ma      <= 8'h00;
                mb      <= 8'h00;
                noise   <= 8'h5A;
            end else begin
                noise <= 8'($urandom_range(1, 255));
                if (beat == 0 && alu_ui[g][7:4] == 4'hA) beat <= 1;
                else if (beat == 1) begin
                    ma   <= alu_ui[g];
                    beat <= 2;
                end else if (beat == 2) begin
                    mb      <= alu_ui[g];
                    beat    <= 0;
                    armed   <= 1'b1;
                    since_b <= 0;
                end else if (armed) begin
                    since_b <= since_b + 1;
                    if (since_b == int'(L)) armed <= 1'b0;
                end
            end
        end
        assign alu_uo[g] = (armed && since_b == int'(L)) ? 8'(ma + mb) : (8'(ma + mb) ^ noise);

        // Scoreboard pop on each rising edge of rsp_valid.
        logic prev;
        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) prev <= 1'b0;
            else begin
                prev <= rsp_valid[g];
                if (rsp_valid[g] && !prev) score(g, rsp_data[g]);
            end
        end
    end

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 7);
    endfunction

    task automatic run_txn(int d, logic [7:0] a, logic [7:0] b, logic [7:0] exp, int stall, bit early);
        int cyc;
        check("req_ready_idle", int'(req_ready[d]), 1);
        req_valid[d] = 1'b1;
        req_op[d]    = 4'h0;
        req_a[d]     = a;
        req_b[d]     = b;
        rsp_ready[d] = early;
        sb.push_back('{d, exp});
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_a[d]     = ~a;
        req_b[d]     = ~b;
        check("busy_frame", int'(busy[d]), 1);
        cyc = 0;
        while (!rsp_valid[d] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", cyc, 3 + lat_of(d));
        if (!early) begin
            for (int i = 0; i < stall; i++) begin
                check("hold_valid", int'(rsp_valid[d]), 1);
                check("hold_data", int'(rsp_data[d]), int'(exp));
                check("hold_req_ready", int'(req_ready[d]), 0);
                @(negedge clk);
            end
            rsp_ready[d] = 1'b1;
        end
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("post_valid", int'(rsp_valid[d]), 0);
        check("post_req_ready", int'(req_ready[d]), 1);
        check("post_busy", int'(busy[d]), 0);
    endtask

    task automatic wait_rsp(int d, int exp_cyc);
        int cyc;
        cyc = 0;
        while (!rsp_valid[d] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", cyc, exp_cyc);
    endtask

    typedef struct {
        int         dut;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        int         stall;
        bit         early;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h12, 8'h34, 8'h46, 0, 1'b0};
        vecs[1] = '{0, 8'hFF, 8'h02, 8'h01, 1, 1'b0};
        vecs[2] = '{1, 8'h80, 8'h80, 8'h00, 2, 1'b0};
        vecs[3] = '{1, 8'h0F, 8'h01, 8'h10, 0, 1'b1};
        vecs[4] = '{2, 8'h7F, 8'h01, 8'h80, 3, 1'b0};
        vecs[5] = '{2, 8'hAA, 8'h55, 8'hFF, 0, 1'b1};
        vecs[6] = '{0, 8'hA5, 8'hA0, 8'h45, 0, 1'b1};
        vecs[7] = '{2, 8'h00, 8'h00, 8'h00, 1, 1'b0};

        for (int i = 0; i < NDUT; i++) begin
            req_valid[i] = 1'b0;
            req_op[i]    = 4'h0;
            req_a[i]     = 8'h00;
            req_b[i]     = 8'h00;
            rsp_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_alu_ui", int'(alu_ui[i]), 8'h00);
            check("rst_rsp_valid", int'(rsp_valid[i]), 0);
            check("rst_rsp_data", int'(rsp_data[i]), 0);
            check("rst_busy", int'(busy[i]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) check("rst_req_ready", int'(req_ready[i]), 1);

        // Single add with beat sequence, then 10 cycles of backpressure.
        req_valid[0] = 1'b1;
        req_a[0]     = 8'h12;
        req_b[0]     = 8'h34;
        sb.push_back('{0, 8'h46});
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("beat_op", int'(alu_ui[0]), 8'hA0);
        check("beat_busy", int'(busy[0]), 1);
        @(negedge clk);
        check("beat_a", int'(alu_ui[0]), 8'h12);
        @(negedge clk);
        check("beat_b", int'(alu_ui[0]), 8'h34);
        @(negedge clk);
        check("beat_idle", int'(alu_ui[0]), 8'h00);
        check("wait_busy", int'(busy[0]), 1);
        wait_rsp(0, 2);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", int'(rsp_valid[0]), 1);
            check("bp_data", int'(rsp_data[0]), 8'h46);
            check("bp_req_ready", int'(req_ready[0]), 0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("bp_post_valid", int'(rsp_valid[0]), 0);
        check("bp_post_req_ready", int'(req_ready[0]), 1);
        @(negedge clk);
        check("bp_single_hs", int'(rsp_valid[0]), 0);

        // Wrap, with a request held valid across the whole frame.
        req_valid[0] = 1'b1;
        req_a[0]     = 8'hFF;
        req_b[0]     = 8'h02;
        sb.push_back('{0, 8'h01});
        @(negedge clk);
        req_a[0] = 8'h10;
        req_b[0] = 8'h20;
        wait_rsp(0, 5);
        check("held_no_accept", int'(alu_ui[0]), 8'h00);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("held_idle_ready", int'(req_ready[0]), 1);
        check("held_idle_busy", int'(busy[0]), 0);
        sb.push_back('{0, 8'h30});
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("held_accept_busy", int'(busy[0]), 1);
        check("held_accept_beat", int'(alu_ui[0]), 8'hA0);
        wait_rsp(0, 5);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;

        // Reset while the A beat is on the bus.
        req_valid[0] = 1'b1;
        req_a[0]     = 8'h33;
        req_b[0]     = 8'h44;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("abort_beat_a", int'(alu_ui[0]), 8'h33);
        rst_n = 1'b0;
        #1;
        check("abort_alu_ui", int'(alu_ui[0]), 8'h00);
        check("abort_rsp_valid", int'(rsp_valid[0]), 0);
        check("abort_busy", int'(busy[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_rsp", int'(rsp_valid[0]), 0);
        run_txn(0, 8'h33, 8'h44, 8'h77, 0, 1'b0);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, vecs[i].early);

`ifdef ALU_DRV_STATS_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("stats_rst_count", int'(txn_count[0]), 0);
        run_txn(0, 8'h01, 8'h02, 8'h03, 0, 1'b1);
        run_txn(0, 8'h05, 8'h06, 8'h0B, 4, 1'b0);
        run_txn(0, 8'h10, 8'h20, 8'h30, 0, 1'b0);
        check("stats_count", int'(txn_count[0]), 3);
        check("stats_stall", int'(stall_seen[0]), 1);
        rst_n = 1'b0;
        #1;
        check("stats_clr_count", int'(txn_count[0]), 0);
        check("stats_clr_stall", int'(stall_seen[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
